// File: rtl/seletor_mapa_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seletor_mapa_if                                           |
// | Brief    : Map-selector bus: map words, commands and selected output |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface seletor_mapa_if #(
    parameter int LARGURA = 7,
    parameter int N_MAPAS = 4,
    parameter int SEL_W   = 3
) ();
    logic [N_MAPAS*LARGURA-1:0] mapas;
    logic [SEL_W-1:0]           sel_in;
    logic                       carregar;
    logic                       avancar;
    logic                       modo_auto;
    logic [LARGURA-1:0]         out;
    logic [SEL_W-1:0]           sel_atual;
    logic                       troca;
    logic                       erro;

    modport master (
        output mapas, sel_in, carregar, avancar, modo_auto,
        input  out, sel_atual, troca, erro
    );

    modport slave (
        input  mapas, sel_in, carregar, avancar, modo_auto,
        output out, sel_atual, troca, erro
    );
endinterface
`default_nettype wire

// File: rtl/seletor_mapa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seletor_mapa                                              |
// | Brief    : Registered map selector with load, step and auto-cycling  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seletor_mapa #(
    parameter int LARGURA = 7,
    parameter int N_MAPAS = 4,
    parameter int SEL_W   = 3,
    parameter int PERIODO = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    seletor_mapa_if.slave  bus
);
    localparam int               c_CNT_W   = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int               c_SLOTS   = 2 ** SEL_W;
    localparam logic [SEL_W:0]   c_N_MAPAS = (SEL_W + 1)'(N_MAPAS);
    localparam logic [SEL_W-1:0] c_ULTIMO  = SEL_W'(N_MAPAS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FIM = c_CNT_W'(PERIODO - 1);

    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [LARGURA-1:0] out_q,   out_d;
    logic [c_CNT_W-1:0] cnt_q,   cnt_d;
    logic               troca_q, troca_d;
    logic               erro_q,  erro_d;

    logic               w_tick;
    logic               w_carga_ok;
    logic [SEL_W-1:0]   w_incr;
    logic [SEL_W-1:0]   w_prox;
    logic [LARGURA-1:0] w_mapa [c_SLOTS];

    // Unpopulated slots read as zero so any index value selects a defined word.
    generate
        for (genvar gi = 0; gi < c_SLOTS; gi++) begin : g_unpack
            if (gi < N_MAPAS) begin : g_valido
                assign w_mapa[gi] = bus.mapas[gi*LARGURA +: LARGURA];
            end else begin : g_vazio
                assign w_mapa[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_tick     = bus.modo_auto && (cnt_q == c_CNT_FIM);
        w_carga_ok = bus.carregar && ({1'b0, bus.sel_in} < c_N_MAPAS);
        w_incr     = (sel_q == c_ULTIMO) ? '0 : sel_q + 1'b1;

        w_prox = sel_q;
        erro_d = 1'b0;
        if (bus.carregar) begin
            if (w_carga_ok) begin
                w_prox = bus.sel_in;
            end else begin
                erro_d = 1'b1;
            end
        end else if (bus.avancar || w_tick) begin
            w_prox = w_incr;
        end

        // Any command, a tick, or leaving auto mode restarts the period.
        cnt_d = cnt_q + 1'b1;
        if (!bus.modo_auto || bus.carregar || bus.avancar || w_tick) begin
            cnt_d = '0;
        end

        sel_d   = w_prox;
        out_d   = w_mapa[w_prox];
        troca_d = (w_prox != sel_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            troca_q <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            troca_q <= troca_d;
            erro_q  <= erro_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.sel_atual = sel_q;
    assign bus.troca     = troca_q;
    assign bus.erro      = erro_q;
endmodule
`default_nettype wire

// File: tb/tb_seletor_mapa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seletor_mapa                                           |
// | Brief    : Self-checking bench for seletor_mapa against a ref model  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_seletor_mapa;
    localparam int LARGURA = 7;
    localparam int N_MAPAS = 4;
    localparam int SEL_W   = 3;
    localparam int PERIODO = 3;
    localparam logic [6:0] c_M0 = 7'b1000001;
    localparam logic [6:0] c_M1 = 7'b1100011;
    localparam logic [6:0] c_M2 = 7'b1110111;
    localparam logic [6:0] c_M3 = 7'b1111001;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    logic [6:0] maps [N_MAPAS];
    int         m_sel;
    int         m_cnt;
    logic [6:0] m_out;
    logic       m_troca;
    logic       m_erro;

    seletor_mapa_if #(.LARGURA(LARGURA), .N_MAPAS(N_MAPAS), .SEL_W(SEL_W)) bus ();

    seletor_mapa #(
        .LARGURA(LARGURA), .N_MAPAS(N_MAPAS), .SEL_W(SEL_W), .PERIODO(PERIODO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_maps(input logic [6:0] a, input logic [6:0] b,
                            input logic [6:0] c, input logic [6:0] d);
        maps[0] = a; maps[1] = b; maps[2] = c; maps[3] = d;
        bus.mapas = {d, c, b, a};
    endtask

    // Reference model: applies the selection rules to the inputs about to be
    // sampled, then advances one clock edge.
    task automatic step();
        int prox;
        bit tick;
        if (reset) begin
            m_sel = 0; m_cnt = 0; m_out = '0; m_troca = 1'b0; m_erro = 1'b0;
        end else begin
            tick   = bus.modo_auto && (m_cnt == PERIODO - 1);
            prox   = m_sel;
            m_erro = 1'b0;
            if (bus.carregar) begin
                if (int'(bus.sel_in) < N_MAPAS) prox = int'(bus.sel_in);
                else m_erro = 1'b1;
            end else if (bus.avancar || tick) begin
                prox = (m_sel + 1) % N_MAPAS;
            end
            if (!bus.modo_auto || bus.carregar || bus.avancar || tick) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            m_troca = (prox != m_sel);
            m_sel   = prox;
            m_out   = maps[prox];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        tests_run++;
        if ({bus.out, bus.sel_atual, bus.troca, bus.erro} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_values: out=%b sel=%0d troca=%b erro=%b, expected all zero",
                     bus.out, bus.sel_atual, bus.troca, bus.erro);
        end
        reset = 1'b0;
        step(); step();
        tests_run++;
        if (bus.out !== c_M0 || bus.sel_atual !== 3'd0 || bus.troca !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: out=%b sel=%0d troca=%b, expected out=%b sel=0 troca=0",
                     bus.out, bus.sel_atual, bus.troca, c_M0);
        end
    endtask

    task automatic test_load();
        bus.carregar = 1'b1; bus.sel_in = 3'd2;
        step();
        tests_run++;
        if (bus.out !== c_M2 || bus.sel_atual !== 3'd2 || bus.troca !== 1'b1 || bus.erro !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_2: out=%b sel=%0d troca=%b erro=%b, expected out=%b sel=2 troca=1 erro=0",
                     bus.out, bus.sel_atual, bus.troca, bus.erro, c_M2);
        end
        step();
        tests_run++;
        if (bus.troca !== 1'b0 || bus.sel_atual !== 3'd2) begin
            tests_failed++;
            $display("FAIL load_same: troca=%b sel=%0d, expected troca=0 sel=2", bus.troca, bus.sel_atual);
        end
        bus.sel_in = 3'd5;
        step();
        bus.carregar = 1'b0;
        tests_run++;
        if (bus.erro !== 1'b1 || bus.out !== c_M2 || bus.sel_atual !== 3'd2 || bus.troca !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_invalid: erro=%b out=%b sel=%0d troca=%b, expected erro=1 out=%b sel=2 troca=0",
                     bus.erro, bus.out, bus.sel_atual, bus.troca, c_M2);
        end
        step();
        tests_run++;
        if (bus.erro !== 1'b0) begin
            tests_failed++;
            $display("FAIL erro_pulse_width: erro=%b, expected 0", bus.erro);
        end
    endtask

    task automatic test_advance();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd1; exp_seq[1] = 3'd2; exp_seq[2] = 3'd3; exp_seq[3] = 3'd0;
        bus.carregar = 1'b1; bus.sel_in = 3'd3;
        step();
        bus.carregar = 1'b0; bus.avancar = 1'b1;
        step();
        tests_run++;
        if (bus.sel_atual !== 3'd0 || bus.out !== c_M0 || bus.troca !== 1'b1) begin
            tests_failed++;
            $display("FAIL advance_wrap: sel=%0d out=%b troca=%b, expected sel=0 out=%b troca=1",
                     bus.sel_atual, bus.out, bus.troca, c_M0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (bus.sel_atual !== exp_seq[i] || bus.troca !== 1'b1) begin
                tests_failed++;
                $display("FAIL advance_hold[%0d]: sel=%0d troca=%b, expected sel=%0d troca=1",
                         i, bus.sel_atual, bus.troca, exp_seq[i]);
            end
        end
        bus.avancar = 1'b0;
        step();
    endtask

    task automatic test_auto();
        logic [2:0] exp_a [6];
        logic [2:0] exp_b [5];
        exp_a[0] = 3'd0; exp_a[1] = 3'd0; exp_a[2] = 3'd1;
        exp_a[3] = 3'd1; exp_a[4] = 3'd1; exp_a[5] = 3'd2;
        exp_b[0] = 3'd2; exp_b[1] = 3'd3; exp_b[2] = 3'd3; exp_b[3] = 3'd3; exp_b[4] = 3'd0;
        bus.modo_auto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if (bus.sel_atual !== exp_a[i]) begin
                tests_failed++;
                $display("FAIL auto_period edge %0d: sel=%0d, expected %0d", i + 1, bus.sel_atual, exp_a[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            bus.avancar = (i == 1);
            step();
            tests_run++;
            if (bus.sel_atual !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL auto_with_advance edge %0d: sel=%0d, expected %0d", i + 1, bus.sel_atual, exp_b[i]);
            end
        end
        bus.avancar = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (bus.out !== 7'd0 || bus.sel_atual !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_auto: out=%b sel=%0d, expected out=0 sel=0", bus.out, bus.sel_atual);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (bus.sel_atual !== ((i == 2) ? 3'd1 : 3'd0) || bus.out !== ((i == 2) ? c_M1 : c_M0)) begin
                tests_failed++;
                $display("FAIL auto_after_reset edge %0d: sel=%0d out=%b", i + 1, bus.sel_atual, bus.out);
            end
        end
        bus.modo_auto = 1'b0;
        step();
    endtask

    task automatic test_priority();
        reset = 1'b1; bus.modo_auto = 1'b1;
        step();
        reset = 1'b0;
        step(); step();
        bus.carregar = 1'b1; bus.sel_in = 3'd3; bus.avancar = 1'b1;
        step();
        bus.carregar = 1'b0; bus.avancar = 1'b0;
        tests_run++;
        if (bus.sel_atual !== 3'd3 || bus.out !== c_M3 || bus.troca !== 1'b1) begin
            tests_failed++;
            $display("FAIL priority_load: sel=%0d out=%b troca=%b, expected sel=3 out=%b troca=1",
                     bus.sel_atual, bus.out, bus.troca, c_M3);
        end
        step(); step();
        tests_run++;
        if (bus.sel_atual !== 3'd3) begin
            tests_failed++;
            $display("FAIL priority_cnt_cleared: sel=%0d, expected 3", bus.sel_atual);
        end
        step();
        tests_run++;
        if (bus.sel_atual !== 3'd0) begin
            tests_failed++;
            $display("FAIL priority_next_tick: sel=%0d, expected 0", bus.sel_atual);
        end
        bus.modo_auto = 1'b0;
        step();
    endtask

    task automatic test_live_map();
        bus.carregar = 1'b1; bus.sel_in = 3'd1;
        step();
        bus.carregar = 1'b0;
        step();
        set_maps(c_M0, 7'b0000000, c_M2, c_M3);
        step();
        tests_run++;
        if (bus.out !== 7'b0000000 || bus.troca !== 1'b0 || bus.sel_atual !== 3'd1) begin
            tests_failed++;
            $display("FAIL live_map: out=%b troca=%b sel=%0d, expected out=0000000 troca=0 sel=1",
                     bus.out, bus.troca, bus.sel_atual);
        end
        set_maps(c_M0, c_M1, c_M2, c_M3);
        step();
        tests_run++;
        if (bus.out !== c_M1) begin
            tests_failed++;
            $display("FAIL live_map_restore: out=%b, expected %b", bus.out, c_M1);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 49) == 0);
            bus.carregar  = ($urandom_range(0, 5) == 0);
            bus.sel_in    = 3'($urandom_range(0, 7));
            bus.avancar   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) bus.modo_auto = ~bus.modo_auto;
            if ($urandom_range(0, 9) == 0)
                set_maps(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
            step();
            tests_run++;
            if ({bus.out, bus.sel_atual, bus.troca, bus.erro} !== {m_out, 3'(m_sel), m_troca, m_erro}) begin
                tests_failed++;
                if (errs < 10)
                    $display("FAIL random[%0d]: out=%b sel=%0d troca=%b erro=%b, expected out=%b sel=%0d troca=%b erro=%b",
                             i, bus.out, bus.sel_atual, bus.troca, bus.erro, m_out, m_sel, m_troca, m_erro);
                errs++;
            end
        end
        reset = 1'b0; bus.carregar = 1'b0; bus.avancar = 1'b0; bus.modo_auto = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        bus.carregar  = 1'b0;
        bus.avancar   = 1'b0;
        bus.modo_auto = 1'b0;
        bus.sel_in    = '0;
        m_sel = 0; m_cnt = 0; m_out = '0; m_troca = 1'b0; m_erro = 1'b0;
        set_maps(c_M0, c_M1, c_M2, c_M3);
        test_reset();
        test_load();
        test_advance();
        test_auto();
        test_priority();
        test_live_map();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
